// File: rtl/regdump_pkg.sv
// Shared constants and FSM state type for the register dump/load initiator.
package regdump_pkg;

  localparam int unsigned NUM_REGS = 8;
  localparam int unsigned WORD_W   = 16;
  localparam int unsigned IDX_W    = 3;

  typedef enum logic [2:0] {
    StIdle,
    StDCap,
    StDSend,
    StLWait,
    StLWrite,
    StFin
  } state_e;

endpackage

// File: rtl/reg_dump_loader_if.sv
// Control, register-unit and stream signals of the dump/load initiator.
// Signal prefixes are from the initiator's point of view.
interface reg_dump_loader_if;
  import regdump_pkg::*;

  logic              i_grant;
  logic              i_dump_req;
  logic              i_load_req;
  logic [WORD_W-1:0] i_rd_data;
  logic [IDX_W-1:0]  o_sr_sel;
  logic [IDX_W-1:0]  o_dr_sel;
  logic              o_ld_reg;
  logic [WORD_W-1:0] o_bus_out;
  logic              o_bus_en;
  logic [WORD_W-1:0] o_out_data;
  logic              o_out_valid;
  logic              i_out_ready;
  logic [WORD_W-1:0] i_in_data;
  logic              i_in_valid;
  logic              o_in_ready;
  logic              o_busy;
  logic              o_done;
  logic              o_abort;

  modport master (
    input  i_grant, i_dump_req, i_load_req, i_rd_data, i_out_ready, i_in_data, i_in_valid,
    output o_sr_sel, o_dr_sel, o_ld_reg, o_bus_out, o_bus_en, o_out_data, o_out_valid,
    output o_in_ready, o_busy, o_done, o_abort
  );

  modport slave (
    output i_grant, i_dump_req, i_load_req, i_rd_data, i_out_ready, i_in_data, i_in_valid,
    input  o_sr_sel, o_dr_sel, o_ld_reg, o_bus_out, o_bus_en, o_out_data, o_out_valid,
    input  o_in_ready, o_busy, o_done, o_abort
  );

endinterface

// File: rtl/dump_index_counter.sv
// Register index counter with synchronous clear, increment and terminal flag.
module dump_index_counter
  import regdump_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_last
);

  logic [IDX_W-1:0] r_idx;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_idx <= '0;
    end else if (i_clr) begin
      r_idx <= '0;
    end else if (i_inc) begin
      r_idx <= r_idx + 1'b1;
    end
  end

  assign o_idx  = r_idx;
  assign o_last = (r_idx == IDX_W'(NUM_REGS - 1));

endmodule

// File: rtl/reg_dump_loader.sv
// Sequences the register unit's SR1 read port and DR write port to dump
// R0..R7 onto an output stream or load them from an input stream.
module reg_dump_loader
  import regdump_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst_n,
  reg_dump_loader_if.master   rdl
);

  state_e            r_state, w_state_nxt;
  logic [WORD_W-1:0] r_hold;
  logic [IDX_W-1:0]  w_idx;
  logic              w_last, w_clr, w_inc, w_cap_rd, w_cap_in;

  dump_index_counter u_idx (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (w_clr),
    .i_inc   (w_inc),
    .o_idx   (w_idx),
    .o_last  (w_last)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hold <= '0;
    end else if (w_cap_rd) begin
      r_hold <= rdl.i_rd_data;
    end else if (w_cap_in) begin
      r_hold <= rdl.i_in_data;
    end
  end

  // Grant loss aborts from any busy state; handshakes and writes in that cycle are gated off.
  always_comb begin
    w_state_nxt     = r_state;
    w_clr           = 1'b0;
    w_inc           = 1'b0;
    w_cap_rd        = 1'b0;
    w_cap_in        = 1'b0;
    rdl.o_sr_sel    = w_idx;
    rdl.o_dr_sel    = w_idx;
    rdl.o_ld_reg    = 1'b0;
    rdl.o_bus_out   = '0;
    rdl.o_bus_en    = 1'b0;
    rdl.o_out_data  = '0;
    rdl.o_out_valid = 1'b0;
    rdl.o_in_ready  = 1'b0;
    rdl.o_busy      = 1'b0;
    rdl.o_done      = 1'b0;
    rdl.o_abort     = 1'b0;
    case (r_state)
      StIdle: begin
        w_clr = 1'b1;
        if (rdl.i_grant && rdl.i_dump_req) begin
          w_state_nxt = StDCap;
        end else if (rdl.i_grant && rdl.i_load_req) begin
          w_state_nxt = StLWait;
        end
      end
      StDCap: begin
        rdl.o_busy = 1'b1;
        if (!rdl.i_grant) begin
          rdl.o_abort = 1'b1;
          w_state_nxt = StIdle;
        end else begin
          w_cap_rd    = 1'b1;
          w_state_nxt = StDSend;
        end
      end
      StDSend: begin
        rdl.o_busy      = 1'b1;
        rdl.o_out_data  = r_hold;
        rdl.o_out_valid = rdl.i_grant;
        if (!rdl.i_grant) begin
          rdl.o_abort = 1'b1;
          w_state_nxt = StIdle;
        end else if (rdl.i_out_ready) begin
          w_inc       = !w_last;
          w_state_nxt = w_last ? StFin : StDCap;
        end
      end
      StLWait: begin
        rdl.o_busy     = 1'b1;
        rdl.o_in_ready = rdl.i_grant;
        if (!rdl.i_grant) begin
          rdl.o_abort = 1'b1;
          w_state_nxt = StIdle;
        end else if (rdl.i_in_valid) begin
          w_cap_in    = 1'b1;
          w_state_nxt = StLWrite;
        end
      end
      StLWrite: begin
        rdl.o_busy    = 1'b1;
        rdl.o_bus_en  = 1'b1;
        rdl.o_bus_out = r_hold;
        rdl.o_ld_reg  = rdl.i_grant;
        if (!rdl.i_grant) begin
          rdl.o_abort = 1'b1;
          w_state_nxt = StIdle;
        end else begin
          w_inc       = !w_last;
          w_state_nxt = w_last ? StFin : StLWait;
        end
      end
      StFin: begin
        rdl.o_done  = 1'b1;
        w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

endmodule

// File: tb/tb_reg_dump_loader.sv
// Randomized bench for reg_dump_loader with a behavioural register-file model.
module tb_reg_dump_loader;
  import regdump_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reg_dump_loader_if rif ();

  reg_dump_loader u_dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .rdl     (rif.master)
  );

  // Register unit: combinational SR1 read, clocked DR write.
  logic [15:0] regs [8];
  assign rif.i_rd_data = regs[rif.o_sr_sel];
  always @(posedge clk) if (rif.o_ld_reg && rif.o_bus_en) regs[rif.o_dr_sel] <= rif.o_bus_out;

  wire [44:0] all_out = {rif.o_sr_sel, rif.o_dr_sel, rif.o_ld_reg, rif.o_bus_out, rif.o_bus_en,
                         rif.o_out_data, rif.o_out_valid, rif.o_in_ready, rif.o_busy,
                         rif.o_done, rif.o_abort};

  int total = 0;
  int bad = 0;

  // Expected register contents, updated from the sequence rules only.
  logic [15:0] exp_regs [8];
  logic [15:0] ld_data [8];

  logic [15:0] got_q [$];
  int          beat_cyc [$];
  int          done_cyc, ld_seen, stall_bad, d_timeout;
  logic [2:0]  ld_dr_q [$];
  logic [15:0] ld_bus_q [$];
  int          ld_cnt, l_done, bus_en_bad, l_timeout;
  logic        ab_ld, ab_abort, ab_done, pre_ld, rst_ld, rst_bus_en, rst_busy;

  // mode 0: ready always 1, 1: random ready, 2: ready pattern 1,0,0,1
  task automatic run_dump(input int mode, input bit with_load);
    bit          prev_stall;
    logic [15:0] prev_data;
    got_q.delete(); beat_cyc.delete();
    done_cyc = -1; ld_seen = 0; stall_bad = 0; d_timeout = 0; prev_stall = 0; prev_data = '0;
    @(negedge clk);
    rif.i_grant = 1'b1; rif.i_dump_req = 1'b1; rif.i_load_req = with_load; rif.i_out_ready = 1'b0;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      rif.i_dump_req = 1'b0; rif.i_load_req = 1'b0;
      case (mode)
        0: rif.i_out_ready = 1'b1;
        1: rif.i_out_ready = 1'($urandom_range(0, 1));
        default: rif.i_out_ready = ((c % 4) == 0) || ((c % 4) == 3);
      endcase
      #1;
      if (prev_stall && (!rif.o_out_valid || rif.o_out_data !== prev_data)) stall_bad++;
      if (rif.o_ld_reg) ld_seen++;
      if (rif.o_out_valid && rif.i_out_ready) begin
        got_q.push_back(rif.o_out_data);
        beat_cyc.push_back(c);
      end
      prev_stall = rif.o_out_valid && !rif.i_out_ready;
      prev_data  = rif.o_out_data;
      if (rif.o_done) begin
        done_cyc = c;
        break;
      end
    end
    if (done_cyc < 0) d_timeout = 1;
    rif.i_out_ready = 1'b0;
  endtask

  task automatic run_load(input bit rand_valid, input int abort_at, input int reset_at);
    int nxt, wr_pend;
    bit ended;
    ld_dr_q.delete(); ld_bus_q.delete();
    ld_cnt = 0; l_done = 0; bus_en_bad = 0; l_timeout = 0; ended = 0; nxt = 0; wr_pend = -1;
    @(negedge clk);
    rif.i_grant = 1'b1; rif.i_load_req = 1'b1; rif.i_in_valid = 1'b0;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      rif.i_load_req = 1'b0;
      rif.i_in_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      rif.i_in_data  = (nxt < 8) ? ld_data[nxt] : 16'h0;
      if (wr_pend >= 0 && wr_pend == abort_at) rif.i_grant = 1'b0;
      #1;
      if (wr_pend >= 0 && wr_pend == abort_at) begin
        ab_ld = rif.o_ld_reg; ab_abort = rif.o_abort; ab_done = rif.o_done;
        ended = 1;
      end else if (wr_pend >= 0 && wr_pend == reset_at) begin
        pre_ld = rif.o_ld_reg;
        #1 rst_n = 1'b0;
        #1;
        rst_ld = rif.o_ld_reg; rst_bus_en = rif.o_bus_en; rst_busy = rif.o_busy;
        ended = 1;
      end else begin
        if (rif.o_ld_reg) begin
          ld_cnt++;
          ld_dr_q.push_back(rif.o_dr_sel);
          ld_bus_q.push_back(rif.o_bus_out);
          if (!rif.o_bus_en) bus_en_bad++;
        end
        if (rif.o_done) begin
          l_done++;
          ended = 1;
        end else if (rif.i_in_valid && rif.o_in_ready) begin
          wr_pend = nxt;
          nxt++;
        end else begin
          wr_pend = -1;
        end
      end
      if (ended) break;
    end
    if (!ended) l_timeout = 1;
    rif.i_in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    total++;
    if (all_out !== 45'd0) begin
      bad++; $display("FAIL reset_outputs: got %h want 0", all_out);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); #1;
    total++;
    if (rif.o_busy !== 1'b0) begin
      bad++; $display("FAIL reset_busy: got %b want 0", rif.o_busy);
    end
  endtask

  task automatic test_load(input bit rand_valid, input logic [15:0] base, input bit rand_data);
    for (int i = 0; i < 8; i++) ld_data[i] = rand_data ? 16'($urandom) : base + 16'(i);
    run_load(rand_valid, -1, -1);
    total++;
    if (l_timeout != 0 || l_done != 1) begin
      bad++; $display("FAIL load_done: got timeout=%0d done=%0d want 0/1", l_timeout, l_done);
    end
    total++;
    if (ld_cnt != 8) begin
      bad++; $display("FAIL load_ld_count: got %0d want 8", ld_cnt);
    end
    total++;
    if (bus_en_bad != 0) begin
      bad++; $display("FAIL load_bus_en: got %0d writes without BUS_En want 0", bus_en_bad);
    end
    for (int i = 0; i < ld_dr_q.size() && i < 8; i++) begin
      total++;
      if (ld_dr_q[i] !== 3'(i) || ld_bus_q[i] !== ld_data[i]) begin
        bad++; $display("FAIL load_write[%0d]: got dr=%0d bus=%h want dr=%0d bus=%h",
                        i, ld_dr_q[i], ld_bus_q[i], i, ld_data[i]);
      end
    end
    for (int i = 0; i < 8; i++) exp_regs[i] = ld_data[i];
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      total++;
      if (regs[i] !== exp_regs[i]) begin
        bad++; $display("FAIL load_regfile[%0d]: got %h want %h", i, regs[i], exp_regs[i]);
      end
    end
  endtask

  task automatic test_dump(input int mode, input bit with_load);
    run_dump(mode, with_load);
    total++;
    if (d_timeout != 0 || got_q.size() != 8) begin
      bad++; $display("FAIL dump_count: got timeout=%0d beats=%0d want 0/8", d_timeout, got_q.size());
    end
    for (int i = 0; i < got_q.size() && i < 8; i++) begin
      total++;
      if (got_q[i] !== exp_regs[i]) begin
        bad++; $display("FAIL dump_word[%0d]: got %h want %h", i, got_q[i], exp_regs[i]);
      end
    end
    total++;
    if (ld_seen != 0 || stall_bad != 0) begin
      bad++; $display("FAIL dump_side: got ld_reg=%0d unstable=%0d want 0/0", ld_seen, stall_bad);
    end
    if (mode == 0) begin
      for (int i = 0; i < beat_cyc.size() && i < 8; i++) begin
        total++;
        if (beat_cyc[i] != 2 * i + 2) begin
          bad++; $display("FAIL dump_timing[%0d]: got cycle %0d want %0d", i, beat_cyc[i], 2 * i + 2);
        end
      end
      total++;
      if (done_cyc != 17) begin
        bad++; $display("FAIL dump_done_cycle: got %0d want 17", done_cyc);
      end
    end
    @(negedge clk); #1;
    total++;
    if ({rif.o_done, rif.o_busy} !== 2'b00) begin
      bad++; $display("FAIL dump_after: got done,busy=%b want 00", {rif.o_done, rif.o_busy});
    end
  endtask

  task automatic test_no_grant();
    @(negedge clk);
    rif.i_grant = 1'b0; rif.i_dump_req = 1'b1; rif.i_load_req = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      total++;
      if ({rif.o_busy, rif.o_in_ready, rif.o_out_valid, rif.o_abort} !== 4'b0) begin
        bad++; $display("FAIL nogrant_idle[%0d]: got %b want 0000", c,
                        {rif.o_busy, rif.o_in_ready, rif.o_out_valid, rif.o_abort});
      end
    end
    @(negedge clk);
    rif.i_grant = 1'b1; rif.i_dump_req = 1'b0; rif.i_load_req = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      total++;
      if (rif.o_busy !== 1'b0) begin
        bad++; $display("FAIL nogrant_queued[%0d]: got busy=%b want 0", c, rif.o_busy);
      end
    end
  endtask

  task automatic test_abort_lwrite();
    logic [15:0] old3;
    old3 = exp_regs[3];
    for (int i = 0; i < 8; i++) ld_data[i] = 16'hB000 + 16'(i);
    run_load(1'b0, 3, -1);
    total++;
    if ({ab_ld, ab_abort, ab_done} !== 3'b010) begin
      bad++; $display("FAIL abort_cycle: got ld,abort,done=%b want 010", {ab_ld, ab_abort, ab_done});
    end
    total++;
    if (ld_cnt != 3 || l_done != 0) begin
      bad++; $display("FAIL abort_writes: got writes=%0d done=%0d want 3/0", ld_cnt, l_done);
    end
    @(negedge clk); #1;
    total++;
    if ({rif.o_busy, rif.o_abort, rif.o_done} !== 3'b000) begin
      bad++; $display("FAIL abort_after: got busy,abort,done=%b want 000",
                      {rif.o_busy, rif.o_abort, rif.o_done});
    end
    rif.i_grant = 1'b1;
    for (int i = 0; i < 3; i++) exp_regs[i] = ld_data[i];
    total++;
    if (regs[3] !== old3) begin
      bad++; $display("FAIL abort_r3: got %h want %h", regs[3], old3);
    end
    test_dump(0, 1'b0);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 8; i++) ld_data[i] = 16'hC000 + 16'(i);
    run_load(1'b0, -1, 2);
    total++;
    if ({pre_ld, rst_ld, rst_bus_en, rst_busy} !== 4'b1000) begin
      bad++; $display("FAIL reset_mid: got pre_ld,ld,bus_en,busy=%b want 1000",
                      {pre_ld, rst_ld, rst_bus_en, rst_busy});
    end
    @(negedge clk); rst_n = 1'b1; #1;
    total++;
    if ({rif.o_busy, rif.o_sr_sel, rif.o_dr_sel, rif.o_in_ready} !== 8'h00) begin
      bad++; $display("FAIL reset_release: got busy,sr,dr,in_ready=%b want 0",
                      {rif.o_busy, rif.o_sr_sel, rif.o_dr_sel, rif.o_in_ready});
    end
    for (int i = 0; i < 2; i++) exp_regs[i] = ld_data[i];
    total++;
    if (regs[2] !== exp_regs[2]) begin
      bad++; $display("FAIL reset_r2: got %h want %h", regs[2], exp_regs[2]);
    end
    test_dump(0, 1'b0);
  endtask

  initial begin
    rif.i_grant = 1'b0; rif.i_dump_req = 1'b0; rif.i_load_req = 1'b0;
    rif.i_out_ready = 1'b0; rif.i_in_data = '0; rif.i_in_valid = 1'b0;
    test_reset();
    test_load(1'b0, 16'h1000, 1'b0);
    test_dump(0, 1'b0);
    test_load(1'b0, 16'hA5A0, 1'b0);
    test_dump(2, 1'b0);
    test_dump(0, 1'b1);
    test_no_grant();
    for (int k = 0; k < 3; k++) begin
      test_load(1'b1, 16'h0, 1'b1);
      test_dump(1, 1'b0);
    end
    test_abort_lwrite();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
